// File: rtl/perf_meas_pkg.sv
// Shared types and defaults for the simulation-rate measurement sequencer.
package perf_meas_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        RUN,
        FLUSH,
        DONE
    } state_e;

endpackage

// File: rtl/perf_meas_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module perf_meas_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/perf_meas_sched.sv
// Measurement-window sequencer: warm-up skip, baseline mark, periodic cycle
// reports over a valid/ack handshake, and a final partial report on stop.
module perf_meas_sched
    import perf_meas_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int DEFAULT_WINDOW = 1000,
    parameter int DEFAULT_WARMUP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_window,
    input  logic [CNT_W-1:0] cfg_warmup,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    output logic             meas_req,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             meas_discard,
    output logic             meas_last,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] WIN_RST =
        (DEFAULT_WINDOW == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_WINDOW);
    localparam logic [CNT_W-1:0] WUP_RST = CNT_W'(DEFAULT_WARMUP);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] win_d, win_q;
    logic [CNT_W-1:0] wup_d, wup_q;
    logic             req_d, req_q;
    logic [CNT_W-1:0] cycles_d, cycles_q;
    logic             discard_d, discard_q;
    logic             last_d, last_q;

    logic             cyc_clr, cyc_inc;
    logic             stall_clr, stall_inc;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W:0]   cyc_p1;
    logic [CNT_W-1:0] cyc_p1_sat;
    logic             pending;

    perf_meas_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cyc_clr),
        .inc   (cyc_inc),
        .count (cyc)
    );

    perf_meas_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (stall_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    // cyc+1 is kept one bit wider so a saturated count still compares as due.
    assign cyc_p1     = {1'b0, cyc} + (CNT_W+1)'(1);
    assign cyc_p1_sat = (cyc == '1) ? cyc : cyc_p1[CNT_W-1:0];
    assign pending    = req_q & ~meas_ack;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        wup_d     = wup_q;
        req_d     = req_q & ~meas_ack;
        cycles_d  = cycles_q;
        discard_d = discard_q;
        last_d    = last_q;
        cyc_clr   = 1'b0;
        cyc_inc   = 1'b0;
        stall_clr = 1'b0;
        stall_inc = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    win_d = (cfg_window == '0) ? CNT_W'(1) : cfg_window;
                    wup_d = cfg_warmup;
                end
                if (start && !stop) begin
                    cyc_clr   = 1'b1;
                    stall_clr = 1'b1;
                    if (wup_q != '0) begin
                        state_d = WARMUP;
                    end else begin
                        state_d   = RUN;
                        req_d     = 1'b1;
                        cycles_d  = '0;
                        discard_d = 1'b1;
                        last_d    = 1'b0;
                    end
                end
            end

            WARMUP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cyc_p1 == {1'b0, wup_q}) begin
                    state_d   = RUN;
                    cyc_clr   = 1'b1;
                    req_d     = 1'b1;
                    cycles_d  = '0;
                    discard_d = 1'b1;
                    last_d    = 1'b0;
                end else begin
                    cyc_inc = 1'b1;
                end
            end

            RUN: begin
                // Stop wins over a due report; the stop cycle lands in the final flush.
                if (stop) begin
                    state_d = FLUSH;
                    cyc_inc = 1'b1;
                end else if (cyc_p1 >= {1'b0, win_q}) begin
                    if (!pending) begin
                        req_d     = 1'b1;
                        cycles_d  = cyc_p1_sat;
                        discard_d = 1'b0;
                        last_d    = 1'b0;
                        cyc_clr   = 1'b1;
                    end else begin
                        cyc_inc   = 1'b1;
                        stall_inc = 1'b1;
                    end
                end else begin
                    cyc_inc = 1'b1;
                end
            end

            FLUSH: begin
                if (!pending) begin
                    state_d = DONE;
                    if (cyc != '0) begin
                        req_d     = 1'b1;
                        cycles_d  = cyc;
                        discard_d = 1'b0;
                        last_d    = 1'b1;
                        cyc_clr   = 1'b1;
                    end
                end
            end

            DONE: begin
                if (!req_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_q     <= WIN_RST;
            wup_q     <= WUP_RST;
            req_q     <= 1'b0;
            cycles_q  <= '0;
            discard_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            wup_q     <= wup_d;
            req_q     <= req_d;
            cycles_q  <= cycles_d;
            discard_q <= discard_d;
            last_q    <= last_d;
        end
    end

    assign cfg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign meas_req     = req_q;
    assign meas_cycles  = cycles_q;
    assign meas_discard = discard_q;
    assign meas_last    = last_q;

endmodule
